// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - configuration-chain loader: word stream to serial ccff_head, with tail readback CRC-16
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 68,
    parameter int WORD_W    = 8,
    parameter int TIMEOUT   = 1024
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       tail_crc
);

    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int SW = $clog2(TIMEOUT + 1);
    localparam int LW = $clog2(WORD_W + 1);

    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, DONE, ERR} state_t;

    state_t            state;
    logic [CW-1:0]     bit_cnt;
    logic [SW-1:0]     stall_cnt;
    logic [LW-1:0]     word_left;
    logic [WORD_W-1:0] shreg;
    logic [CW-1:0]     remaining;
    logic              fb;

    assign remaining = CW'(CHAIN_LEN) - bit_cnt;
    assign fb        = tail_crc[15] ^ ccff_tail;

    // Outputs decode straight from the state register so an async reset drops them at once.
    assign bs_ready      = (state == FETCH);
    assign ccff_shift_en = (state == SHIFT);
    assign ccff_head     = (state == SHIFT) & shreg[WORD_W-1];
    assign busy          = (state == FETCH) || (state == SHIFT);
    assign done          = (state == DONE);
    assign err           = (state == ERR);

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            stall_cnt <= '0;
            word_left <= '0;
            shreg     <= '0;
            tail_crc  <= 16'hFFFF;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        bit_cnt   <= '0;
                        stall_cnt <= '0;
                        tail_crc  <= 16'hFFFF;
                        state     <= FETCH;
                    end else if (state == DONE) begin
                        state <= IDLE;
                    end
                end
                FETCH: begin
                    if (bs_valid) begin
                        shreg     <= bs_data;
                        // The last word may be partial; its low bits are never shifted.
                        word_left <= (32'(remaining) >= WORD_W) ? LW'(WORD_W) : LW'(remaining);
                        stall_cnt <= '0;
                        state     <= SHIFT;
                    end else if (stall_cnt == SW'(TIMEOUT - 1)) begin
                        stall_cnt <= SW'(TIMEOUT);
                        state     <= ERR;
                    end else begin
                        stall_cnt <= stall_cnt + SW'(1);
                    end
                end
                SHIFT: begin
                    shreg     <= shreg << 1;
                    bit_cnt   <= bit_cnt + CW'(1);
                    word_left <= word_left - LW'(1);
                    tail_crc  <= {tail_crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
                    if (bit_cnt == CW'(CHAIN_LEN - 1)) begin
                        state <= DONE;
                    end else if (word_left == LW'(1)) begin
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - scoreboard bench for ccff_chain_loader
module tb_ccff_chain_loader;

    localparam int CL = 12;

    logic prog_clk = 1'b0;
    logic pReset;
    always #5 prog_clk = ~prog_clk;

    logic       m_start, m_valid, m_ready, m_head, m_shift, m_tail, m_busy, m_done, m_err;
    logic [7:0] m_data;
    logic [15:0] m_crc;

    logic       c_start, c_valid, c8_tail, c72_tail;
    logic [7:0] c_data;
    logic       c8_ready, c8_head, c8_shift, c8_busy, c8_done, c8_err;
    logic       c72_ready, c72_head, c72_shift, c72_busy, c72_done, c72_err;
    logic [15:0] c8_crc, c72_crc;

    ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(8), .TIMEOUT(16)) u_main (
        .prog_clk(prog_clk), .pReset(pReset), .start(m_start), .bs_data(m_data),
        .bs_valid(m_valid), .bs_ready(m_ready), .ccff_head(m_head), .ccff_shift_en(m_shift),
        .ccff_tail(m_tail), .busy(m_busy), .done(m_done), .err(m_err), .tail_crc(m_crc));

    ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(8), .TIMEOUT(16)) u_crc8 (
        .prog_clk(prog_clk), .pReset(pReset), .start(c_start), .bs_data(c_data),
        .bs_valid(c_valid), .bs_ready(c8_ready), .ccff_head(c8_head), .ccff_shift_en(c8_shift),
        .ccff_tail(c8_tail), .busy(c8_busy), .done(c8_done), .err(c8_err), .tail_crc(c8_crc));

    ccff_chain_loader #(.CHAIN_LEN(72), .WORD_W(8), .TIMEOUT(16)) u_crc72 (
        .prog_clk(prog_clk), .pReset(pReset), .start(c_start), .bs_data(c_data),
        .bs_valid(c_valid), .bs_ready(c72_ready), .ccff_head(c72_head), .ccff_shift_en(c72_shift),
        .ccff_tail(c72_tail), .busy(c72_busy), .done(c72_done), .err(c72_err), .tail_crc(c72_crc));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic q[$];
    int   pushed;
    int   shift_cnt = 0;
    int   hs_cnt = 0;
    int   done_cnt = 0;

    always @(negedge prog_clk) begin
        if (m_shift) begin
            shift_cnt++;
            if (q.size() != 0) check("head", 32'(m_head), 32'(q.pop_front()));
            else check("sb_underflow", 32'(shift_cnt), 32'(0));
        end
        if (m_valid && m_ready) hs_cnt++;
        if (m_done) done_cnt++;
    end

    task automatic start_load(output time t);
        @(posedge prog_clk);
        #1 m_start = 1'b1;
        @(posedge prog_clk);
        t = $time;
        #1 m_start = 1'b0;
    endtask

    task automatic wait_ready();
        logic ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge prog_clk);
            ok = m_ready;
        end
        if (!ok) check("ready_timeout", 32'(m_ready), 32'(1));
    endtask

    task automatic send_word(input logic [7:0] w, input int gap);
        int n;
        n = (CL - pushed < 8) ? CL - pushed : 8;
        for (int i = 0; i < n; i++) q.push_back(w[7-i]);
        pushed += n;
        if (gap > 0) begin
            m_valid = 1'b0;
            wait_ready();
            repeat (gap) @(posedge prog_clk);
            #1;
        end
        m_data  = w;
        m_valid = 1'b1;
        wait_ready();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic wait_done(output time t);
        logic ok = 1'b0;
        t = 0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge prog_clk);
            if (m_done) begin
                ok = 1'b1;
                t  = $time;
            end
        end
        if (!ok) check("done_timeout", 32'(m_done), 32'(1));
    endtask

    task automatic load2(input logic [7:0] w0, input logic [7:0] w1, input int gap, output time lat);
        time ts, td;
        start_load(ts);
        pushed = 0;
        send_word(w0, 0);
        send_word(w1, gap);
        m_valid = 1'b0;
        wait_done(td);
        lat = td - ts;
    endtask

    task automatic run_test(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                            input int gap, input int exp_lat, input logic pulse);
        int s, h, d;
        time lat;
        s = shift_cnt; h = hs_cnt; d = done_cnt;
        fork
            load2(w0, w1, gap, lat);
            if (pulse) begin
                repeat (5) @(posedge prog_clk);
                #1 m_start = 1'b1;
                @(posedge prog_clk);
                #1 m_start = 1'b0;
            end
        join
        @(negedge prog_clk);
        check({tag, "_busy_after"}, 32'(m_busy), 32'(0));
        check({tag, "_done_pulse"}, 32'(m_done), 32'(0));
        #1;
        check({tag, "_shifts"}, 32'(shift_cnt - s), 32'(CL));
        check({tag, "_handshakes"}, 32'(hs_cnt - h), 32'(2));
        check({tag, "_dones"}, 32'(done_cnt - d), 32'(1));
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_sb_left"}, 32'(q.size()), 32'(0));
        check({tag, "_err"}, 32'(m_err), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time %0t limit 200000", $time);
        $fatal(1, "watchdog");
    end

    logic [71:0] msg;
    int          idx;
    logic        ok;
    time         ts;
    int          s;

    initial begin
        pReset = 1'b0;
        m_start = 1'b0; m_valid = 1'b0; m_data = 8'h00; m_tail = 1'b0;
        c_start = 1'b0; c_valid = 1'b1; c_data = 8'h00; c8_tail = 1'b0; c72_tail = 1'b0;
        msg = "123456789";
        #12;
        check("rst_ready", 32'(m_ready), 32'(0));
        check("rst_shift", 32'(m_shift), 32'(0));
        check("rst_head", 32'(m_head), 32'(0));
        check("rst_flags", 32'({m_busy, m_done, m_err}), 32'(0));
        check("rst_crc", 32'(m_crc), 32'hFFFF);
        #11 pReset = 1'b1;

        // Known-answer readback CRCs
        @(posedge prog_clk);
        #1 c_start = 1'b1;
        @(posedge prog_clk);
        #1 c_start = 1'b0;
        idx = 0;
        ok  = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge prog_clk);
            if (c72_shift) begin
                c72_tail = msg[71-idx];
                idx++;
            end
            if (c72_done) ok = 1'b1;
        end
        if (!ok) check("crc72_done_timeout", 32'(c72_done), 32'(1));
        check("crc8", 32'(c8_crc), 32'hE1F0);
        check("crc72", 32'(c72_crc), 32'h29B1);
        check("crc72_bits", 32'(idx), 32'(72));
        @(negedge prog_clk);
        check("crc8_idle", 32'({c8_busy, c8_err, c8_ready, c8_shift, c8_head, c8_done}), 32'(0));
        check("crc72_idle", 32'({c72_busy, c72_err, c72_ready, c72_shift, c72_head, c72_done}), 32'(0));

        run_test("basic", 8'hA5, 8'h3F, 0, 145, 1'b0);
        run_test("pattern", 8'h5A, 8'hC3, 0, 145, 1'b0);
        run_test("gaps", 8'hA5, 8'h3F, 3, 175, 1'b0);
        run_test("busy_start", 8'hA5, 8'h3F, 0, 145, 1'b1);

        // Stall timeout
        s = shift_cnt;
        start_load(ts);
        m_valid = 1'b0;
        repeat (16) @(negedge prog_clk);
        check("to_err_pre", 32'(m_err), 32'(0));
        check("to_busy_pre", 32'(m_busy), 32'(1));
        @(negedge prog_clk);
        check("to_err", 32'(m_err), 32'(1));
        check("to_busy", 32'(m_busy), 32'(0));
        check("to_ready", 32'(m_ready), 32'(0));
        repeat (3) @(negedge prog_clk);
        check("to_err_sticky", 32'(m_err), 32'(1));
        check("to_no_shift", 32'(shift_cnt - s), 32'(0));
        run_test("after_err", 8'h96, 8'hF0, 0, 145, 1'b0);

        // Async reset mid-shift
        start_load(ts);
        pushed = 0;
        send_word(8'hA5, 0);
        repeat (3) @(posedge prog_clk);
        #3 pReset = 1'b0;
        #1;
        check("ar_shift", 32'(m_shift), 32'(0));
        check("ar_busy", 32'(m_busy), 32'(0));
        check("ar_ready", 32'(m_ready), 32'(0));
        check("ar_crc", 32'(m_crc), 32'hFFFF);
        m_valid = 1'b0;
        q.delete();
        #17 pReset = 1'b1;
        run_test("post_reset", 8'hA5, 8'h3F, 0, 145, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Configuration-chain programming controller for a logic tile.
- Accepts a bitstream as WORD_W-bit words over a valid/ready stream and serialises it MSB-first onto the tile's ccff_head.
- Qualifies the chain's programming clock with a shift enable, and stops after exactly CHAIN_LEN shifts.
- While loading, folds the bits displaced out of ccff_tail (the previous configuration) into a CRC-16, giving the host a readback signature of the old contents.

Parameters:
- CHAIN_LEN, 68, total configuration flip-flops in the chain (frac_logic bits plus output-mux memories); must be ≥1.
- WORD_W, 8, bitstream word width; must be ≥1.
- TIMEOUT, 1024, consecutive FETCH cycles without bs_valid before the error state is entered.

Ports:
- prog_clk  in  1  programming clock; all state updates on its rising edge.
- pReset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- bs_data  in  WORD_W  bitstream word; bit WORD_W-1 is shifted first.
- bs_valid  in  1  bs_data valid.
- bs_ready  out  1  word accepted when bs_valid&bs_ready at a rising edge.
- ccff_head  out  1  serial config data to the chain head.
- ccff_shift_en  out  1  chain clock enable; the chain shifts on every prog_clk edge where it is 1.
- ccff_tail  in  1  serial output of the chain tail.
- busy  out  1  high in FETCH or SHIFT.
- done  out  1  one-cycle pulse when CHAIN_LEN bits have been shifted.
- err  out  1  sticky stall-timeout flag.
- tail_crc  out  16  CRC of the tail bits shifted out during the current or last load.

Behaviour:
- Reset (pReset=0, async) forces state=IDLE, bit_cnt=0, stall_cnt=0, shreg=0, tail_crc=16'hFFFF, and all outputs to 0.
  - Reset mid-load abandons the load; chain contents are undefined.
- States: IDLE, FETCH, SHIFT, DONE, ERR.
- IDLE: bs_ready=0, ccff_shift_en=0.
  - On start: bit_cnt←0, stall_cnt←0, tail_crc←16'hFFFF, go to FETCH.
- FETCH: bs_ready=1.
  - On handshake: shreg←bs_data, word_left←min(WORD_W, CHAIN_LEN−bit_cnt), stall_cnt←0, go to SHIFT.
  - Without bs_valid: stall_cnt increments; when it reaches TIMEOUT, go to ERR.
- SHIFT: bs_ready=0, ccff_shift_en=1, ccff_head=shreg[WORD_W−1] (combinational from registers). At each edge:
  - shreg shifts left with zero fill.
  - bit_cnt and word_left update (+1 and −1).
  - tail_crc updates with the ccff_tail value present before the edge.
  - If bit_cnt reaches CHAIN_LEN, go to DONE; else if word_left reaches 0, go to FETCH.
  - Unused low bits of the final partial word are discarded.
- Throughput: one FETCH cycle per word minimum, so each word costs word_left+1 cycles.
- DONE: done=1 for exactly one cycle, then IDLE. A start in DONE goes straight to FETCH (re-initialising as in IDLE).
- ERR: err=1, busy=0, ccff_shift_en=0.
  - Stays in ERR until start (clears err, re-initialises as in IDLE, goes to FETCH) or reset.
- ccff_head=0 whenever ccff_shift_en=0.
- start while busy is ignored.
- bs_valid in IDLE/SHIFT/DONE/ERR is ignored; no word is consumed.
- tail_crc is CRC-16/CCITT-FALSE, computed serially:
  - fb = tail_crc[15]^ccff_tail;
  - tail_crc ← {tail_crc[14:0],1'b0} ^ (fb ? 16'h1021 : 16'h0000).
  - No final XOR; it holds its value outside SHIFT until the next start.
- Counter widths: bit_cnt uses $clog2(CHAIN_LEN+1) bits; stall_cnt uses $clog2(TIMEOUT+1) bits. Neither counter wraps.

Test Plan:
- Basic serialisation: CHAIN_LEN=12, WORD_W=8. Start, then words 0xA5, 0x3F with bs_valid always high.
  - Required: ccff_head per shift = 1,0,1,0,0,1,0,1,0,0,1,1.
  - Required: ccff_shift_en high exactly 12 cycles (8, one FETCH gap, 4).
  - Required: exactly 2 handshakes, one done pulse, busy low after.
- Readback CRC: CHAIN_LEN=8, ccff_tail held 0 → tail_crc=16'hE1F0.
  - CHAIN_LEN=72, ccff_tail driven MSB-first with ASCII "123456789" → tail_crc=16'h29B1.
- Stall timeout: TIMEOUT=16. Start, then hold bs_valid=0.
  - Required: err rises after 16 FETCH cycles; ccff_shift_en stays 0.
  - Required: a new start clears err and accepts words normally.
- Back-pressure gaps: insert 3 idle cycles between words, then keep them valid.
  - Required: no shifts during gaps; identical head sequence to the gap-free case; stall_cnt resets per word (no err with TIMEOUT=16).
- Start while busy: pulse start mid-SHIFT.
  - Required: no restart; bit count and done timing unchanged.
- Async reset: pReset low in mid-SHIFT, asynchronous to prog_clk.
  - Required: ccff_shift_en, busy and bs_ready drop immediately; tail_crc=16'hFFFF.
  - Required: after release, the next start loads the full CHAIN_LEN bits.
